// File: rtl/pipe_hazard_sequencer_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   state_t      : sequencer FSM states (RUN, MEM_WAIT, BR_FLUSH)
//   REG_ADDR_W   : architectural register index width
//   cnt_w()      : wait-counter width for a given SRAM access length
package pipe_pkg;

  localparam int REG_ADDR_W = 4;

  localparam int SRAM_WAIT_CYCLES_DEF = 6;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    BR_FLUSH = 2'd2
  } state_t;

  // Counter holds at most SRAM_WAIT_CYCLES-1, so clog2 bits suffice;
  // keep at least one bit for the degenerate single-cycle access.
  function automatic int cnt_w(input int wait_cycles);
    return (wait_cycles <= 1) ? 1 : $clog2(wait_cycles);
  endfunction

  localparam int CNT_W_DEF = cnt_w(SRAM_WAIT_CYCLES_DEF);

endpackage

// File: rtl/pipe_hazard_sequencer_if.sv
// Bundle between the pipeline datapath and the stall/flush sequencer.
//   master : pipeline side; drives ID sources, EXE/MEM destinations,
//            mem_access and B; receives Hazard, freeze/flush enables and
//            the SRAM start/done pulses.
//   slave  : the sequencer; the mirror image.
interface pipe_hazard_sequencer_if;
  import pipe_pkg::*;

  logic [REG_ADDR_W-1:0] Rn;
  logic [REG_ADDR_W-1:0] Rm;
  logic                  src1_valid;
  logic                  two_src;
  logic [REG_ADDR_W-1:0] EXE_Dest;
  logic                  EXE_WB_EN;
  logic                  EXE_MEM_R_EN;
  logic [REG_ADDR_W-1:0] MEM_Dest;
  logic                  MEM_WB_EN;
  logic                  mem_access;
  logic                  B;

  logic                  Hazard;
  logic                  freeze_all;
  logic                  flush_if_id;
  logic                  flush_id_exe;
  logic                  sram_start;
  logic                  mem_done;

  modport master (
    output Rn, Rm, src1_valid, two_src, EXE_Dest, EXE_WB_EN, EXE_MEM_R_EN,
           MEM_Dest, MEM_WB_EN, mem_access, B,
    input  Hazard, freeze_all, flush_if_id, flush_id_exe, sram_start, mem_done
  );

  modport slave (
    input  Rn, Rm, src1_valid, two_src, EXE_Dest, EXE_WB_EN, EXE_MEM_R_EN,
           MEM_Dest, MEM_WB_EN, mem_access, B,
    output Hazard, freeze_all, flush_if_id, flush_id_exe, sram_start, mem_done
  );

endinterface

// File: rtl/pipe_hazard_sequencer_hazard_detect.sv
// Combinational data-hazard term for the ID stage.
//   Inputs : ID sources (Rn, Rm, src1_valid, two_src), EXE destination
//            (EXE_Dest, EXE_WB_EN, EXE_MEM_R_EN), MEM destination
//            (MEM_Dest, MEM_WB_EN).
//   Output : hazard - ID must bubble.
// Build option PIPE_FORWARDING_EN: when defined only an EXE load-use
// dependency stalls; everything else is covered by forwarding.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] Rn,
  input  logic [REG_ADDR_W-1:0] Rm,
  input  logic                  src1_valid,
  input  logic                  two_src,
  input  logic [REG_ADDR_W-1:0] EXE_Dest,
  input  logic                  EXE_WB_EN,
  input  logic                  EXE_MEM_R_EN,
  input  logic [REG_ADDR_W-1:0] MEM_Dest,
  input  logic                  MEM_WB_EN,
  output logic                  hazard
);

  logic rn_exe, rm_exe, rn_mem, rm_mem;

  assign rn_exe = src1_valid & EXE_WB_EN & (Rn == EXE_Dest);
  assign rm_exe = two_src    & EXE_WB_EN & (Rm == EXE_Dest);
  assign rn_mem = src1_valid & MEM_WB_EN & (Rn == MEM_Dest);
  assign rm_mem = two_src    & MEM_WB_EN & (Rm == MEM_Dest);

`ifdef PIPE_FORWARDING_EN
  // A load result is not available until after MEM, so it cannot be
  // forwarded to the instruction directly behind it.
  assign hazard = EXE_MEM_R_EN & (rn_exe | rm_exe);

  logic unused_mem_match;
  assign unused_mem_match = rn_mem | rm_mem;
`else
  assign hazard = rn_exe | rm_exe | rn_mem | rm_mem;

  logic unused_load;
  assign unused_load = EXE_MEM_R_EN;
`endif

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// Central stall/flush sequencer for the five-stage pipeline.
//   clk, rst : clock and synchronous active-high reset
//   bus      : pipe_hazard_sequencer_if.slave - ID/EXE/MEM hazard inputs,
//              mem_access, B; drives Hazard, freeze_all, flush_if_id,
//              flush_id_exe, sram_start, mem_done (all combinational from
//              the FSM state and the current inputs).
// Parameter SRAM_WAIT_CYCLES (1..15): cycles one SRAM access holds MEM.
// Build option PIPE_FORWARDING_EN selects the load-use-only hazard term.
module pipe_hazard_sequencer
  import pipe_pkg::*;
#(
  parameter int SRAM_WAIT_CYCLES = SRAM_WAIT_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  pipe_hazard_sequencer_if.slave bus
);

  localparam int             CNT_W = cnt_w(SRAM_WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SRAM_WAIT_CYCLES - 1);
  // A one-cycle access completes in the cycle it starts; no wait state.
  localparam bit             MULTI = (SRAM_WAIT_CYCLES > 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             data_hz;
  logic             wait_last;

  logic hazard_c, freeze_c, flush_c, start_c, done_c;

  hazard_detect u_hazard_detect (
    .Rn          (bus.Rn),
    .Rm          (bus.Rm),
    .src1_valid  (bus.src1_valid),
    .two_src     (bus.two_src),
    .EXE_Dest    (bus.EXE_Dest),
    .EXE_WB_EN   (bus.EXE_WB_EN),
    .EXE_MEM_R_EN(bus.EXE_MEM_R_EN),
    .MEM_Dest    (bus.MEM_Dest),
    .MEM_WB_EN   (bus.MEM_WB_EN),
    .hazard      (data_hz)
  );

  // The counter is loaded with SRAM_WAIT_CYCLES-1 and reaches zero on the
  // edge that closes the last wait cycle, so that cycle sees cnt == 1.
  assign wait_last = (state == MEM_WAIT) && (cnt == CNT_W'(1));

  always_comb begin
    hazard_c = 1'b0;
    freeze_c = 1'b0;
    flush_c  = 1'b0;
    start_c  = 1'b0;
    done_c   = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.mem_access) begin
          start_c = 1'b1;
          if (MULTI) freeze_c = 1'b1;
          else       done_c   = 1'b1;
        end else if (bus.B) begin
          flush_c = 1'b1;
        end else begin
          hazard_c = data_hz;
        end
      end
      MEM_WAIT: begin
        if (wait_last) done_c   = 1'b1;
        else           freeze_c = 1'b1;
      end
      default: ;  // BR_FLUSH: one quiet cycle, everything deasserted
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (bus.mem_access) begin
            if (MULTI) begin
              cnt   <= CNT_LOAD;
              state <= MEM_WAIT;
            end
          end else if (bus.B) begin
            state <= BR_FLUSH;
          end
        end
        MEM_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (wait_last) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.Hazard       = hazard_c;
  assign bus.freeze_all   = freeze_c;
  assign bus.flush_if_id  = flush_c;
  assign bus.flush_id_exe = flush_c;
  assign bus.sram_start   = start_c;
  assign bus.mem_done     = done_c;

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Directed bench for pipe_hazard_sequencer (SRAM_WAIT_CYCLES = 6).
// Output vector order: {Hazard, freeze_all, flush_if_id, flush_id_exe,
// sram_start, mem_done}.
module tb_pipe_hazard_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipe_hazard_sequencer_if bus ();

  pipe_hazard_sequencer #(.SRAM_WAIT_CYCLES(6)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {bus.Hazard, bus.freeze_all, bus.flush_if_id, bus.flush_id_exe,
            bus.sram_start, bus.mem_done};
  endfunction

`ifdef PIPE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Advance to just after the next rising edge; inputs are changed here
  // and outputs sampled 1 time unit later, well away from any edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.Rn = 4'd0; bus.Rm = 4'd0; bus.src1_valid = 1'b0; bus.two_src = 1'b0;
    bus.EXE_Dest = 4'd0; bus.EXE_WB_EN = 1'b0; bus.EXE_MEM_R_EN = 1'b0;
    bus.MEM_Dest = 4'd0; bus.MEM_WB_EN = 1'b0;
    bus.mem_access = 1'b0; bus.B = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] o;
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      #1 o = outs(); checks++;
      if (o !== 6'b000000) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got %b want 000000", i, o);
      end
    end
  endtask

  task automatic test_data_hazard();
    logic [5:0] o;
    clear_inputs();
    next_cycle();
    bus.EXE_WB_EN = 1'b1; bus.EXE_Dest = 4'd3; bus.Rn = 4'd3; bus.src1_valid = 1'b1;
    #1 o = outs(); checks++;
    if (o !== {!FWD, 5'b0}) begin
      errors++; $display("FAIL hz_exe_rn: got %b want %b", o, {!FWD, 5'b0});
    end
    bus.src1_valid = 1'b0; bus.two_src = 1'b0;
    #1 o = outs(); checks++;
    if (o !== 6'b000000) begin
      errors++; $display("FAIL hz_no_src: got %b want 000000", o);
    end
    // Matching register but no writeback: never a hazard.
    bus.src1_valid = 1'b1; bus.EXE_WB_EN = 1'b0;
    #1 o = outs(); checks++;
    if (o !== 6'b000000) begin
      errors++; $display("FAIL hz_no_wb: got %b want 000000", o);
    end
    clear_inputs();
    bus.MEM_WB_EN = 1'b1; bus.MEM_Dest = 4'd5; bus.Rm = 4'd5; bus.two_src = 1'b1;
    #1 o = outs(); checks++;
    if (o !== {!FWD, 5'b0}) begin
      errors++; $display("FAIL hz_mem_rm: got %b want %b", o, {!FWD, 5'b0});
    end
    // Load in EXE writing the same register: stalls in both builds.
    bus.EXE_WB_EN = 1'b1; bus.EXE_MEM_R_EN = 1'b1; bus.EXE_Dest = 4'd5;
    #1 o = outs(); checks++;
    if (o !== 6'b100000) begin
      errors++; $display("FAIL hz_load_use: got %b want 100000", o);
    end
    // Different registers everywhere.
    bus.Rm = 4'd7; bus.Rn = 4'd2; bus.src1_valid = 1'b1;
    #1 o = outs(); checks++;
    if (o !== 6'b000000) begin
      errors++; $display("FAIL hz_no_match: got %b want 000000", o);
    end
    clear_inputs();
  endtask

  task automatic test_sram_wait();
    logic [5:0] o;
    logic [5:0] exp;
    clear_inputs();
    next_cycle();
    // Dependent ID instruction present throughout: Hazard must be masked
    // during the access and reappear once the pipeline runs again.
    bus.EXE_WB_EN = 1'b1; bus.EXE_Dest = 4'd9; bus.Rn = 4'd9; bus.src1_valid = 1'b1;
    bus.mem_access = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 0)      exp = 6'b010010;
      else if (c == 5) exp = 6'b000001;
      else             exp = 6'b010000;
      #1 o = outs(); checks++;
      if (o !== exp) begin
        errors++; $display("FAIL sram_cycle[%0d]: got %b want %b", c, o, exp);
      end
      next_cycle();
    end
    bus.mem_access = 1'b0;
    #1 o = outs(); checks++;
    if (o !== {!FWD, 5'b0}) begin
      errors++; $display("FAIL sram_after_run: got %b want %b", o, {!FWD, 5'b0});
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    logic [5:0] o;
    clear_inputs();
    next_cycle();
    bus.EXE_WB_EN = 1'b1; bus.EXE_Dest = 4'd4; bus.Rn = 4'd4; bus.src1_valid = 1'b1;
    bus.EXE_MEM_R_EN = 1'b1;
    bus.B = 1'b1;
    #1 o = outs(); checks++;
    if (o !== 6'b001100) begin
      errors++; $display("FAIL br_flush: got %b want 001100", o);
    end
    next_cycle();
    bus.B = 1'b0;
    #1 o = outs(); checks++;
    if (o !== 6'b000000) begin
      errors++; $display("FAIL br_quiet: got %b want 000000", o);
    end
    next_cycle();
    #1 o = outs(); checks++;
    if (o !== 6'b100000) begin
      errors++; $display("FAIL br_back_to_run: got %b want 100000", o);
    end
    clear_inputs();
  endtask

  task automatic test_mem_and_branch();
    logic [5:0] o;
    logic [5:0] exp;
    clear_inputs();
    next_cycle();
    bus.mem_access = 1'b1; bus.B = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 0)      exp = 6'b010010;
      else if (c == 5) exp = 6'b000001;
      else             exp = 6'b010000;
      #1 o = outs(); checks++;
      if (o !== exp) begin
        errors++; $display("FAIL memb_cycle[%0d]: got %b want %b", c, o, exp);
      end
      next_cycle();
    end
    bus.mem_access = 1'b0;
    #1 o = outs(); checks++;
    if (o !== 6'b001100) begin
      errors++; $display("FAIL memb_late_flush: got %b want 001100", o);
    end
    next_cycle();
    bus.B = 1'b0;
    #1 o = outs(); checks++;
    if (o !== 6'b000000) begin
      errors++; $display("FAIL memb_br_quiet: got %b want 000000", o);
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [5:0] o;
    logic [5:0] exp;
    clear_inputs();
    next_cycle();
    bus.mem_access = 1'b1;
    // Two accesses: mem_access stays high, the second starts right after
    // the first mem_done cycle.
    for (int c = 0; c < 12; c++) begin
      if (c % 6 == 0)      exp = 6'b010010;
      else if (c % 6 == 5) exp = 6'b000001;
      else                 exp = 6'b010000;
      #1 o = outs(); checks++;
      if (o !== exp) begin
        errors++; $display("FAIL b2b_cycle[%0d]: got %b want %b", c, o, exp);
      end
      next_cycle();
    end
    bus.mem_access = 1'b0;
    #1 o = outs(); checks++;
    if (o !== 6'b000000) begin
      errors++; $display("FAIL b2b_idle: got %b want 000000", o);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_wait();
    logic [5:0] o;
    clear_inputs();
    next_cycle();
    bus.mem_access = 1'b1;
    next_cycle();   // MEM_WAIT 1
    next_cycle();   // MEM_WAIT 2
    next_cycle();   // MEM_WAIT 3
    #1 o = outs(); checks++;
    if (o !== 6'b010000) begin
      errors++; $display("FAIL rmw_pre: got %b want 010000", o);
    end
    rst = 1'b1;
    bus.mem_access = 1'b0;
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1 o = outs(); checks++;
      if (o !== 6'b000000) begin
        errors++; $display("FAIL rmw_idle[%0d]: got %b want 000000", c, o);
      end
      next_cycle();
    end
    // Back in RUN: a branch flushes immediately.
    bus.B = 1'b1;
    #1 o = outs(); checks++;
    if (o !== 6'b001100) begin
      errors++; $display("FAIL rmw_run_state: got %b want 001100", o);
    end
    next_cycle();
    clear_inputs();
    next_cycle();
    // Counter was cleared: a fresh access runs its full length.
    bus.mem_access = 1'b1;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
    end
    bus.mem_access = 1'b0;
    #1 o = outs(); checks++;
    if (o !== 6'b000000) begin
      errors++; $display("FAIL rmw_fresh_access_end: got %b want 000000", o);
    end
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_data_hazard();
    test_sram_wait();
    test_branch();
    test_mem_and_branch();
    test_back_to_back();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute bound so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL timeout: sim time exceeded, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
